// File: rtl/square_locator.sv
// Recovers the bounding box of hit pixels over one scanned OLED frame and reports
// it as start X/Y plus length, mirroring the square renderer's inclusive convention.
module square_locator #(
  parameter int unsigned WIDTH  = 96,
  parameter int unsigned HEIGHT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] pixel_index,
  input  logic        pixel_valid,
  input  logic        pixel_hit,
  output logic [7:0]  X_coord_start,
  output logic [7:0]  Y_coord_start,
  output logic [7:0]  length,
  output logic        is_square,
  output logic        found,
  output logic        result_valid,
  output logic        frame_error
);

  localparam int unsigned NumPix  = WIDTH * HEIGHT;
  localparam logic [12:0] LastIdx = 13'(NumPix - 1);
  localparam logic [12:0] WidthW  = 13'(WIDTH);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e      state_q, state_d;
  logic [12:0] expected_q, expected_d;
  logic [7:0]  xmin_q, xmin_d, ymin_q, ymin_d;
  logic [7:0]  xmax_q, xmax_d, ymax_q, ymax_d;
  logic        any_hit_q, any_hit_d;
  logic [7:0]  x_start_q, x_start_d, y_start_q, y_start_d;
  logic [7:0]  length_q, length_d;
  logic        is_square_q, is_square_d;
  logic        found_q, found_d;
  logic        result_valid_q, result_valid_d;
  logic        frame_error_q, frame_error_d;

  logic [7:0] px, py;
  logic [7:0] w, h;
  logic       start, take;

  assign px = 8'(pixel_index % WidthW);
  assign py = 8'(pixel_index / WidthW);
  assign w  = xmax_q - xmin_q;
  assign h  = ymax_q - ymin_q;

  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    xmin_d         = xmin_q;
    ymin_d         = ymin_q;
    xmax_d         = xmax_q;
    ymax_d         = ymax_q;
    any_hit_d      = any_hit_q;
    x_start_d      = x_start_q;
    y_start_d      = y_start_q;
    length_d       = length_q;
    is_square_d    = is_square_q;
    found_d        = found_q;
    result_valid_d = 1'b0;
    frame_error_d  = 1'b0;
    start          = 1'b0;
    take           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pixel_valid && pixel_index == '0) begin
          start   = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (pixel_valid) begin
          if (pixel_index == '0) begin
            start = 1'b1;
          end else if (pixel_index == expected_q) begin
            take       = 1'b1;
            expected_d = expected_q + 13'd1;
            if (pixel_index == LastIdx) state_d = StDone;
          end else begin
            frame_error_d = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      StDone: begin
        result_valid_d = 1'b1;
        found_d        = any_hit_q;
        if (any_hit_q) begin
          x_start_d   = xmin_q;
          y_start_d   = ymin_q;
          length_d    = (w > h) ? w : h;
          is_square_d = (w == h);
        end else begin
          x_start_d   = '0;
          y_start_d   = '0;
          length_d    = '0;
          is_square_d = 1'b0;
        end
        // A new frame may begin on the very cycle the result is registered.
        if (pixel_valid && pixel_index == '0) begin
          start   = 1'b1;
          state_d = StScan;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      expected_d = 13'd1;
      xmin_d     = 8'hFF;
      ymin_d     = 8'hFF;
      xmax_d     = '0;
      ymax_d     = '0;
      any_hit_d  = 1'b0;
      take       = 1'b1;
    end

    if (take && pixel_hit) begin
      any_hit_d = 1'b1;
      if (px < xmin_d) xmin_d = px;
      if (py < ymin_d) ymin_d = py;
      if (px > xmax_d) xmax_d = px;
      if (py > ymax_d) ymax_d = py;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      expected_q     <= '0;
      xmin_q         <= 8'hFF;
      ymin_q         <= 8'hFF;
      xmax_q         <= '0;
      ymax_q         <= '0;
      any_hit_q      <= 1'b0;
      x_start_q      <= '0;
      y_start_q      <= '0;
      length_q       <= '0;
      is_square_q    <= 1'b0;
      found_q        <= 1'b0;
      result_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      xmin_q         <= xmin_d;
      ymin_q         <= ymin_d;
      xmax_q         <= xmax_d;
      ymax_q         <= ymax_d;
      any_hit_q      <= any_hit_d;
      x_start_q      <= x_start_d;
      y_start_q      <= y_start_d;
      length_q       <= length_d;
      is_square_q    <= is_square_d;
      found_q        <= found_d;
      result_valid_q <= result_valid_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign X_coord_start = x_start_q;
  assign Y_coord_start = y_start_q;
  assign length        = length_q;
  assign is_square     = is_square_q;
  assign found         = found_q;
  assign result_valid  = result_valid_q;
  assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_square_locator.sv
// Scoreboard bench for square_locator: stimulus pushes expected results computed from a
// hit map; a negedge monitor pops and compares whenever result_valid or frame_error fires.
module tb_square_locator;

  localparam int W = 96;
  localparam int H = 64;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] pixel_index = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_hit = 1'b0;
  logic [7:0]  X_coord_start, Y_coord_start, length;
  logic        is_square, found, result_valid, frame_error;

  square_locator #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pixel_index   (pixel_index),
    .pixel_valid   (pixel_valid),
    .pixel_hit     (pixel_hit),
    .X_coord_start (X_coord_start),
    .Y_coord_start (Y_coord_start),
    .length        (length),
    .is_square     (is_square),
    .found         (found),
    .result_valid  (result_valid),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit found;
    int x;
    int y;
    int len;
    bit sq;
    int at;
  } res_t;

  bit   hitmap[N];
  res_t exp_q[$];
  int   err_q[$];
  res_t last_res;
  res_t zero_res;
  int   tests = 0;
  int   fails = 0;

  // Bounding box of every hit pixel in the map, straight from the frame geometry.
  function automatic res_t model();
    res_t r;
    int xmin = W, ymin = H, xmax = -1, ymax = -1;
    int bw, bh;
    r = '{default: 0};
    for (int i = 0; i < N; i++) begin
      if (hitmap[i]) begin
        if (i % W < xmin) xmin = i % W;
        if (i % W > xmax) xmax = i % W;
        if (i / W < ymin) ymin = i / W;
        if (i / W > ymax) ymax = i / W;
      end
    end
    if (xmax >= 0) begin
      bw      = xmax - xmin;
      bh      = ymax - ymin;
      r.found = 1'b1;
      r.x     = xmin;
      r.y     = ymin;
      r.len   = (bw > bh) ? bw : bh;
      r.sq    = (bw == bh);
    end
    return r;
  endfunction

  task automatic clear_map();
    for (int i = 0; i < N; i++) hitmap[i] = 1'b0;
  endtask

  task automatic rect(input int x0, input int y0, input int x1, input int y1);
    clear_map();
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) hitmap[y * W + x] = 1'b1;
  endtask

  task automatic rand_rect();
    int x0, x1, y0, y1;
    x0 = $urandom_range(W - 1);
    x1 = $urandom_range(W - 1, x0);
    y0 = $urandom_range(H - 1);
    y1 = $urandom_range(H - 1, y0);
    rect(x0, y0, x1, y1);
  endtask

  task automatic px(input int idx, input bit hit);
    pixel_index = 13'(idx);
    pixel_valid = 1'b1;
    pixel_hit   = hit;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    pixel_hit   = 1'b0;
  endtask

  task automatic idle(input int n);
    pixel_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full in-order frame from the hit map; result expected one edge after the DONE entry.
  task automatic frame(input bit gaps, input int stall_at);
    res_t r;
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(31) == 0) idle(1);
      if (i == stall_at) idle(50);
      px(i, hitmap[i]);
    end
    r    = model();
    r.at = cyc + 1;
    exp_q.push_back(r);
    last_res = r;
  endtask

  task automatic check_outputs(input string name, input res_t want);
    tests++;
    if (found !== want.found || X_coord_start !== 8'(want.x) || Y_coord_start !== 8'(want.y) ||
        length !== 8'(want.len) || is_square !== want.sq) begin
      fails++;
      $display("FAIL %s: got found=%0d x=%0d y=%0d len=%0d sq=%0d, want found=%0d x=%0d y=%0d len=%0d sq=%0d",
               name, found, X_coord_start, Y_coord_start, length, is_square,
               want.found, want.x, want.y, want.len, want.sq);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid) begin
      res_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result: unexpected result_valid at cycle %0d, want none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (found !== e.found || X_coord_start !== 8'(e.x) || Y_coord_start !== 8'(e.y) ||
            length !== 8'(e.len) || is_square !== e.sq || cyc != e.at) begin
          fails++;
          $display("FAIL result: got found=%0d x=%0d y=%0d len=%0d sq=%0d cyc=%0d, want found=%0d x=%0d y=%0d len=%0d sq=%0d cyc=%0d",
                   found, X_coord_start, Y_coord_start, length, is_square, cyc,
                   e.found, e.x, e.y, e.len, e.sq, e.at);
        end
      end
    end
    if (frame_error) begin
      int a;
      tests++;
      if (err_q.size() == 0) begin
        fails++;
        $display("FAIL frame_error: unexpected pulse at cycle %0d, want none", cyc);
      end else begin
        a = err_q.pop_front();
        if (cyc != a) begin
          fails++;
          $display("FAIL frame_error: pulse at cycle %0d, want cycle %0d", cyc, a);
        end
      end
    end
  end

  initial begin
    zero_res = '{default: 0};
    last_res = zero_res;

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", zero_res);
    tests++;
    if (result_valid !== 1'b0 || frame_error !== 1'b0) begin
      fails++;
      $display("FAIL reset pulses: got rv=%0d fe=%0d, want 0 0", result_valid, frame_error);
    end
    reset_n = 1'b1;
    idle(3);

    rect(10, 5, 20, 15);
    frame(1'b0, -1);
    idle(4);

    clear_map();
    frame(1'b1, -1);
    idle(4);

    rect(0, 63, 95, 63);
    frame(1'b1, -1);
    idle(4);

    // Order fault: jump from 99 to 200.
    rect(30, 30, 40, 40);
    for (int i = 0; i < 100; i++) px(i, hitmap[i]);
    px(200, 1'b1);
    err_q.push_back(cyc);
    idle(4);
    check_outputs("held after fault", last_res);
    rand_rect();
    frame(1'b1, -1);
    idle(4);

    // Restart mid-frame after all-hit partial scan.
    rect(60, 10, 70, 40);
    for (int i = 0; i < 500; i++) px(i, 1'b1);
    frame(1'b0, -1);
    idle(4);

    rand_rect();
    frame(1'b0, 3000);
    idle(4);

    // Back-to-back: frame B's pixel 0 lands on frame A's DONE cycle.
    rect(3, 3, 7, 7);
    frame(1'b0, -1);
    rect(50, 20, 57, 27);
    frame(1'b0, -1);
    idle(4);

    // Asynchronous reset between edges mid-scan.
    rect(5, 5, 80, 50);
    for (int i = 0; i < 1000; i++) px(i, hitmap[i]);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async reset", zero_res);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    last_res = zero_res;
    for (int i = 3000; i < N; i++) px(i, 1'b1);
    idle(4);
    check_outputs("resumed partial ignored", zero_res);
    rand_rect();
    frame(1'b1, -1);
    idle(4);

    clear_map();
    for (int k = 0; k < 5; k++) hitmap[$urandom_range(N - 1)] = 1'b1;
    frame(1'b1, -1);
    idle(2);
    clear_map();
    hitmap[$urandom_range(N - 1)] = 1'b1;
    frame(1'b1, -1);

    for (int t = 0; t < 20 && (exp_q.size() != 0 || err_q.size() != 0); t++) idle(1);
    tests++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results and %0d errors outstanding, want 0 and 0",
               exp_q.size(), err_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
